button_count_source: RTL and testbench



---
 rtl/button_count_pkg.sv | 20 ++
 rtl/button_debouncer.sv | 47 ++++
 rtl/button_count_source.sv | 129 ++++++++++++
 tb/tb_button_count_source.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/button_count_pkg.sv
// Shared constants and types for the pushbutton-driven 8-bit counter.
package button_count_pkg;

    localparam int BTN_UP      = 0;
    localparam int BTN_DOWN    = 1;
    localparam int BTN_LOAD    = 2;
    localparam int NUM_BUTTONS = 3;

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_t;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int width_for(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus run-length debouncer for one active-low button.
module button_debouncer
    import button_count_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic srst,
    input  logic raw,
    output logic stable,
    output logic press
);

    localparam int CW = width_for(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_reg;
    logic [CW-1:0] cnt_reg;
    logic          stable_reg;
    logic          press_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            sync_reg   <= 2'b11;
            cnt_reg    <= '0;
            stable_reg <= 1'b1;
            press_reg  <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], raw};
            press_reg <= 1'b0;
            if (sync_reg[1] == stable_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                // Level has differed long enough: accept it, flag a 1->0 as a press.
                stable_reg <= sync_reg[1];
                cnt_reg    <= '0;
                press_reg  <= ~sync_reg[1];
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign stable = stable_reg;
    assign press  = press_reg;

endmodule

// File: rtl/button_count_source.sv
// Debounced up/down/load pushbuttons driving an 8-bit value with a change strobe.
module button_count_source
    import button_count_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic [2:0] BUTTON,
    input  logic [7:0] SW,
    output logic [7:0] value,
    output logic       changed
);

    localparam int TIMER_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TW = width_for(TIMER_MAX + 1);
    localparam logic [TW-1:0] DELAY_END = TW'(REPEAT_DELAY);
    localparam logic [TW-1:0] RATE_END  = TW'(REPEAT_RATE);

    logic [NUM_BUTTONS-1:0] stable;
    logic [NUM_BUTTONS-1:0] press;
    logic [1:0]             step;
    logic                   load_reg;
    logic [7:0]             value_reg;
    logic                   changed_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BUTTONS; gi++) begin : g_deb
            button_debouncer #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .clk   (CLOCK_50),
                .srst  (RESET),
                .raw   (BUTTON[gi]),
                .stable(stable[gi]),
                .press (press[gi])
            );
        end

        // Auto-repeat for up (index 0) and down (index 1).
        for (gi = 0; gi < 2; gi++) begin : g_rpt
            rpt_state_t    state_reg;
            logic [TW-1:0] timer_reg;
            logic          step_reg;

            always_ff @(posedge CLOCK_50) begin
                if (RESET) begin
                    state_reg <= RPT_IDLE;
                    timer_reg <= '0;
                    step_reg  <= 1'b0;
                end else begin
                    step_reg <= 1'b0;
                    if (stable[gi]) begin
                        state_reg <= RPT_IDLE;
                        timer_reg <= '0;
                    end else begin
                        case (state_reg)
                            RPT_IDLE: begin
                                if (press[gi]) begin
                                    state_reg <= RPT_DELAY;
                                    timer_reg <= TW'(1);
                                    step_reg  <= 1'b1;
                                end
                            end
                            RPT_DELAY: begin
                                if (timer_reg == DELAY_END) begin
                                    state_reg <= RPT_REPEAT;
                                    timer_reg <= TW'(1);
                                    step_reg  <= 1'b1;
                                end else begin
                                    timer_reg <= timer_reg + 1'b1;
                                end
                            end
                            RPT_REPEAT: begin
                                if (timer_reg == RATE_END) begin
                                    timer_reg <= TW'(1);
                                    step_reg  <= 1'b1;
                                end else begin
                                    timer_reg <= timer_reg + 1'b1;
                                end
                            end
                            default: begin
                                state_reg <= RPT_IDLE;
                                timer_reg <= '0;
                            end
                        endcase
                    end
                end
            end

            assign step[gi] = step_reg;
        end
    endgenerate

    // Load is registered so it lines up with the step pulses above.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            load_reg <= 1'b0;
        end else begin
            load_reg <= press[BTN_LOAD] & ~stable[BTN_LOAD];
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            value_reg   <= 8'd0;
            changed_reg <= 1'b0;
        end else begin
            changed_reg <= 1'b0;
            if (load_reg) begin
                value_reg   <= SW;
                changed_reg <= 1'b1;
            end else if (step[BTN_UP] && !step[BTN_DOWN]) begin
                value_reg   <= value_reg + 8'd1;
                changed_reg <= 1'b1;
            end else if (step[BTN_DOWN] && !step[BTN_UP]) begin
                value_reg   <= value_reg - 8'd1;
                changed_reg <= 1'b1;
            end
        end
    end

    assign value   = value_reg;
    assign changed = changed_reg;

endmodule

// File: tb/tb_button_count_source.sv
// Directed and randomized button activity checked cycle by cycle against a behavioural model.
module tb_button_count_source;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RR = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] btn;
    logic [7:0] sw;
    logic [7:0] value;
    logic       changed;

    always #5 clk = ~clk;

    button_count_source #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .CLOCK_50(clk),
        .RESET   (rst),
        .BUTTON  (btn),
        .SW      (sw),
        .value   (value),
        .changed (changed)
    );

    int checks    = 0;
    int errors    = 0;
    int chg_count = 0;
    bit check_en  = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: a button is accepted after D consecutive synchronized samples
    // (raw delayed two edges) disagree with its accepted level; steps fall at fixed
    // ages after the press, and the value register applies them one edge later.
    int         n = 0;
    logic [7:0] m_value = 8'd0;
    bit         m_changed = 1'b0;
    bit         m_stable [3];
    int         m_run    [3];
    int         m_fall   [3];
    bit         m_d0     [3];
    bit         m_d1     [3];
    bit         m_ev     [3];

    function automatic bit step_due(input int age, input bit repeats);
        if (age < 0)   return 1'b0;
        if (age == 0)  return 1'b1;
        if (!repeats)  return 1'b0;
        return (age >= RD) && (((age - RD) % RR) == 0);
    endfunction

    always @(posedge clk) begin
        n++;
        if (rst) begin
            m_value   = 8'd0;
            m_changed = 1'b0;
            for (int b = 0; b < 3; b++) begin
                m_stable[b] = 1'b1;
                m_run[b]    = 0;
                m_fall[b]   = -1000;
                m_d0[b]     = 1'b1;
                m_d1[b]     = 1'b1;
                m_ev[b]     = 1'b0;
            end
        end else begin
            m_changed = 1'b0;
            if (m_ev[2]) begin
                m_value   = sw;
                m_changed = 1'b1;
            end else if (m_ev[0] != m_ev[1]) begin
                m_value   = m_ev[0] ? m_value + 8'd1 : m_value - 8'd1;
                m_changed = 1'b1;
            end
            for (int b = 0; b < 3; b++) begin
                m_ev[b] = !m_stable[b] && step_due(n - m_fall[b] - 1, b != 2);
            end
            for (int b = 0; b < 3; b++) begin
                bit s;
                s       = m_d1[b];
                m_d1[b] = m_d0[b];
                m_d0[b] = btn[b];
                if (s != m_stable[b]) begin
                    m_run[b]++;
                    if (m_run[b] == D) begin
                        m_stable[b] = s;
                        m_run[b]    = 0;
                        if (!s) m_fall[b] = n;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check_val("value", value, m_value);
            check_val("changed", changed, m_changed);
            if (changed) chg_count++;
        end
    end

    task automatic cycles(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic press(input int b, input int len);
        btn[b] = 1'b0;
        cycles(len);
        btn[b] = 1'b1;
        cycles(15);
    endtask

    // Index of the first posedge (counting from 0) after which changed is high; -1 on timeout.
    task automatic wait_change(output int k);
        k = -1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (changed) begin
                k = i;
                return;
            end
        end
    endtask

    int k;
    int c0;

    initial begin
        rst = 1'b1;
        btn = 3'b111;
        sw  = 8'd0;
        @(negedge clk);
        check_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("reset_value", value, 0);
        cycles(20);
        check_val("reset_quiet", chg_count, 0);

        // Bounce shorter than the debounce window.
        btn[0] = 1'b0; cycles(2);
        btn[0] = 1'b1; cycles(1);
        btn[0] = 1'b0; cycles(2);
        btn[0] = 1'b1; cycles(15);
        check_val("bounce_quiet", chg_count, 0);

        // Held up: first step, delay, then repeat rate.
        btn[0] = 1'b0;
        wait_change(k); check_val("first_step_edge", k, 7);
        check_val("first_step_value", value, 1);
        wait_change(k); check_val("repeat_delay", k + 1, RD);
        wait_change(k); check_val("repeat_rate_a", k + 1, RR);
        wait_change(k); check_val("repeat_rate_b", k + 1, RR);
        @(negedge clk);
        btn[0] = 1'b1;
        cycles(10);
        c0 = chg_count;
        cycles(20);
        check_val("release_stop", chg_count - c0, 0);

        // Wrap both ways.
        sw = 8'hFF;
        c0 = chg_count;
        press(2, 8);
        check_val("load_ff_value", value, 255);
        check_val("load_ff_pulses", chg_count - c0, 1);
        press(0, 8);
        check_val("wrap_up", value, 0);
        press(1, 8);
        check_val("wrap_down", value, 255);

        // Long load hold, then reload of the same value.
        sw = 8'hA5;
        c0 = chg_count;
        press(2, 40);
        check_val("load_hold_pulses", chg_count - c0, 1);
        check_val("load_hold_value", value, 165);
        press(2, 8);
        check_val("reload_pulses", chg_count - c0, 2);
        check_val("reload_value", value, 165);

        // Up and down together cancel; load beats up.
        c0 = chg_count;
        btn = 3'b100; cycles(8); btn = 3'b111; cycles(15);
        check_val("up_down_cancel", chg_count - c0, 0);
        sw = 8'h10;
        btn = 3'b010; cycles(8); btn = 3'b111; cycles(15);
        check_val("load_over_up", value, 16);

        // Reset while up is held.
        sw = 8'h00;
        press(2, 8);
        @(negedge clk);
        btn[0] = 1'b0;
        wait_change(k);
        wait_change(k);
        wait_change(k);
        check_val("pre_reset_value", value, 3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("mid_hold_reset", value, 0);
        wait_change(k); check_val("post_reset_edge", k, 7);
        check_val("post_reset_value", value, 1);
        @(negedge clk);
        btn[0] = 1'b1;
        cycles(20);

        // Randomized activity.
        for (int it = 0; it < 250; it++) begin
            logic [2:0] pat;
            for (int b = 0; b < 3; b++) pat[b] = ($urandom_range(0, 2) != 0);
            btn = pat;
            sw  = 8'($urandom);
            if ($urandom_range(0, 49) == 0) rst = 1'b1;
            cycles(1);
            rst = 1'b0;
            cycles($urandom_range(0, 24));
        end
        btn = 3'b111;
        cycles(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
